regfile_wr_ctrl: RTL
====================

# regfile_wr_ctrl

Write-port controller for the 16 x 8-bit register file. It owns the file's single write port (`wr`, `Rw`, `Din`). After reset, or on request, it clears every register by sweeping all addresses. Once cleared, it arbitrates write requests from two requesters, such as a host loader and a datapath result bus, using round-robin priority. Read ports `R1`/`R2` are not touched and connect straight to the register file.

## Interface
- `DW`, 8, data width; matches register file `Din`.
- `AW`, 4, address width; matches register file `Rw`.
- `NREG`, 16, registers swept during clear; must equal 2**AW.
- `CLR_VAL`, 0, value written to every register during a clear sweep.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clr`  in  1  one-cycle pulse; starts a clear sweep (honoured only in IDLE).
- `req0`  in  1  requester 0 write request; held until granted.
- `addr0`  in  AW  requester 0 target register; stable while `req0`=1.
- `data0`  in  DW  requester 0 write data; stable while `req0`=1.
- `gnt0`  out  1  requester 0 write accepted at the coming edge.
- `req1`, `addr1`, `data1`, `gnt1`: same as above, for requester 1.
- `init_done`  out  1  high when the file holds valid contents and requests are accepted.
- `coll`  out  1  both requests target the same address in a cycle where both are pending.
- `wr`  out  1  register file write enable.
- `Rw`  out  AW  register file write address.
- `Din`  out  DW  register file write data.

## Operation
- **States.** The FSM has two states: CLEAR and IDLE. A sweep counter `cnt` is AW+1 bits wide.
- **Reset.** `rst_n`=0 forces CLEAR, `cnt`=0 and the round-robin pointer `last`=1. While `rst_n` is low, all outputs are 0: `wr`, `gnt0`, `gnt1`, `init_done`, `coll`, `Rw`, `Din`.
- **CLEAR state.**
  - Outputs each cycle: `wr`=1, `Rw`=`cnt[AW-1:0]`, `Din`=CLR_VAL.
  - `cnt` increments every cycle.
  - When `cnt`=NREG-1, the next state is IDLE and `cnt` returns to 0.
  - `gnt0`/`gnt1` stay 0 and `init_done` stays 0.
  - `req` inputs are ignored but not lost; requesters keep holding them.
- **IDLE state.**
  - `init_done`=1.
  - Grants are combinational from the current-cycle `req0`/`req1`/`last`:
    - `req0` only → `gnt0`.
    - `req1` only → `gnt1`.
    - Both → grant requester 0 if `last`=1, otherwise requester 1.
  - On a grant: `wr`=1, and `Rw`/`Din` come from the granted requester's `addr`/`data`. `last` updates at the edge to the granted index.
  - With no request: `wr`=0, `Rw`=0, `Din`=0.
- **Clear from IDLE.** `clr`=1 in IDLE moves the FSM to CLEAR at the next edge. A grant in that same cycle still completes; the sweep then overwrites it.
- **`coll` flag.** `coll`=1 when `req0`&`req1`&(`addr0`==`addr1`) in IDLE; combinational. Arbitration is unchanged by it; the loser writes one cycle later, so its data survives.
- **Requester rule.** A requester samples `gnt` at the rising edge. After a grant it may drop `req` or present a new `addr`/`data` in the following cycle.

## Timing
- Write latency: data is in the register file at the same edge where `gnt` is high (zero added cycles).
- Throughput: one write per cycle. Under sustained contention, grants alternate 0,1,0,1…
- Clear sweep: exactly NREG cycles of `wr`=1. `init_done` rises in the cycle after the write to address NREG-1.
- `clr` arriving during CLEAR is ignored; the sweep does not restart.
- `rst_n` asserted mid-sweep or mid-write: outputs go to 0 immediately (asynchronously). A full NREG-cycle sweep follows release.
- `req` held through CLEAR: it is granted in the first IDLE cycle, subject to round-robin.

## Test plan
- **Reset and clear sweep.** Deassert `rst_n`, hold no requests → `wr`=1 for 16 cycles with `Rw`=0..15 and `Din`=0. `init_done` rises on cycle 17; every register then reads 0 via `R1`/`R2`.
- **Single requester.** `req0`, `addr0`=3, `data0`=8'd8 for one cycle → `gnt0`=1, `wr`=1, `Rw`=3, `Din`=8. `R1`=3 then reads 8.
- **Contention and round-robin.** `req0`/`req1` held high, writing `addr0`=0,`data0`=2 and `addr1`=1,`data1`=4 → first grant `gnt0`. `gnt1` next cycle. Strict alternation continues over 6 cycles.
- **Collision.** `req0`(`addr0`=2,`data0`=6) and `req1`(`addr1`=2,`data1`=9) together → `coll`=1 in cycle 1, `gnt0`; cycle 2 `gnt1`. Register 2 final value is 9.
- **Clear in IDLE.** Write 0x55 to register 5, then pulse `clr` → `init_done` drops next cycle, a 16-cycle sweep runs, register 5 reads 0. A `req1` held throughout is granted in the first IDLE cycle.
- **Reset mid-sweep.** Pull `rst_n` low at `cnt`=7 → `wr`=0 at once. After release, the sweep restarts at `Rw`=0 and takes 16 cycles.

Source files
------------

// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the 16x8 register file.
// Clears the file after reset or on request, then round-robins two writers.
module regfile_wr_ctrl #(
  parameter int unsigned          DW      = 8,
  parameter int unsigned          AW      = 4,
  parameter int unsigned          NREG    = 16,
  parameter logic [DW-1:0]        CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  output logic          gnt1,
  output logic          init_done,
  output logic          coll,
  output logic          wr,
  output logic [AW-1:0] Rw,
  output logic [DW-1:0] Din
);

  typedef enum logic {CLEAR, IDLE} state_e;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREG-1);

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          last_q, last_d;

  logic          pick0, pick1;
  logic          wr_c, g0_c, g1_c, done_c, coll_c;
  logic [AW-1:0] rw_c;
  logic [DW-1:0] din_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign pick0 = req0 & (~req1 | last_q);
  assign pick1 = req1 & ~pick0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wr_c    = 1'b0;
    rw_c    = '0;
    din_c   = '0;
    g0_c    = 1'b0;
    g1_c    = 1'b0;
    done_c  = 1'b0;
    coll_c  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        wr_c  = 1'b1;
        rw_c  = cnt_q[AW-1:0];
        din_c = CLR_VAL;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        done_c = 1'b1;
        coll_c = req0 & req1 & (addr0 == addr1);
        unique case (1'b1)
          pick0: begin
            g0_c   = 1'b1;
            wr_c   = 1'b1;
            rw_c   = addr0;
            din_c  = data0;
            last_d = 1'b0;
          end
          pick1: begin
            g1_c   = 1'b1;
            wr_c   = 1'b1;
            rw_c   = addr1;
            din_c  = data1;
            last_d = 1'b1;
          end
          default: ;
        endcase
        // a same-cycle grant still lands; the sweep overwrites it
        if (clr) state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign wr        = rst_n & wr_c;
  assign gnt0      = rst_n & g0_c;
  assign gnt1      = rst_n & g1_c;
  assign init_done = rst_n & done_c;
  assign coll      = rst_n & coll_c;
  assign Rw        = rst_n ? rw_c  : '0;
  assign Din       = rst_n ? din_c : '0;

endmodule
